// File: rtl/kernel_cc_fifo_stream_reader.sv
// Read master for the kernel_cc HLS FIFO. It drains a first-word-fall-through FIFO into a packetised valid/ready stream.
// A one-word pending stage holds each word back so that tlast is already known when the word enters the output register.
module kernel_cc_fifo_stream_reader #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned BURST_LEN  = 16,
    parameter int unsigned TIMEOUT    = 32,
    parameter int unsigned CNT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  if_empty_n,
    output logic                  if_read_ce,
    output logic                  if_read,
    input  logic [DATA_WIDTH-1:0] if_dout,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic [CNT_WIDTH-1:0]  pkt_count
);
    localparam int unsigned BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam int unsigned IDLE_W = $clog2(TIMEOUT + 1);

    logic [DATA_WIDTH-1:0] p_data;
    logic                  p_v;
    logic [BEAT_W-1:0]     beat_cnt;
    logic [IDLE_W-1:0]     idle_cnt;

    logic o_free;
    logic flush;
    logic last_beat;
    logic move;
    logic next_last;

    // Handshake decode: a pending word advances once its tlast is decidable and the output slot is free.
    always_comb begin
        o_free    = !m_axis_tvalid || m_axis_tready;
        flush     = (idle_cnt == IDLE_W'(TIMEOUT));
        last_beat = (beat_cnt == BEAT_W'(BURST_LEN - 1));
        move      = p_v && o_free && (if_empty_n || last_beat || flush);
        next_last = last_beat || !if_empty_n;
        if_read   = !reset && if_empty_n && (!p_v || move);
    end

    assign if_read_ce = 1'b1;

    // Pending stage: refilled on every pop, emptied when its word moves out without a replacement.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            p_data <= '0;
            p_v    <= 1'b0;
        end else if (if_read) begin
            p_data <= if_dout;
            p_v    <= 1'b1;
        end else if (move) begin
            p_v    <= 1'b0;
        end
    end

    // Output stage and beat position within the current packet.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            m_axis_tdata  <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            beat_cnt      <= '0;
        end else if (move) begin
            m_axis_tdata  <= p_data;
            m_axis_tvalid <= 1'b1;
            m_axis_tlast  <= next_last;
            beat_cnt      <= next_last ? '0 : beat_cnt + BEAT_W'(1);
        end else if (o_free) begin
            m_axis_tvalid <= 1'b0;
        end
    end

    // Idle timer: counts only while a word is held back with the FIFO empty, then saturates to hold the flush.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idle_cnt <= '0;
        end else if (!p_v || if_empty_n || move) begin
            idle_cnt <= '0;
        end else if (!flush) begin
            idle_cnt <= idle_cnt + IDLE_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pkt_count <= '0;
        end else if (m_axis_tvalid && m_axis_tready && m_axis_tlast) begin
            pkt_count <= pkt_count + CNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_kernel_cc_fifo_stream_reader.sv
// Bench for kernel_cc_fifo_stream_reader: a queue-backed FWFT FIFO model feeds the DUT; a scoreboard checks the stream beats.
module tb_kernel_cc_fifo_stream_reader;
    localparam int unsigned DW = 64;
    localparam int unsigned BL = 4;
    localparam int unsigned TO = 4;
    localparam int unsigned CW = 32;

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
    } exp_t;

    logic          clk;
    logic          reset = 1'b1;
    logic          if_empty_n = 1'b0;
    logic          if_read_ce;
    logic          if_read;
    logic [DW-1:0] if_dout = '0;
    logic [DW-1:0] m_axis_tdata;
    logic          m_axis_tvalid;
    logic          m_axis_tready = 1'b1;
    logic          m_axis_tlast;
    logic [CW-1:0] pkt_count;

    logic [DW-1:0] fifo_q[$];
    exp_t          exp_q[$];
    int            acc_cyc[$];
    int            total = 0;
    int            bad = 0;
    int            cyc = 0;
    int            empty_cyc = 0;
    int unsigned   exp_pkt = 0;
    logic          s_tvalid, s_tlast, s_if_read;
    logic [DW-1:0] s_tdata;

    kernel_cc_fifo_stream_reader #(
        .DATA_WIDTH(DW), .BURST_LEN(BL), .TIMEOUT(TO), .CNT_WIDTH(CW)
    ) dut (
        .clk(clk), .reset(reset),
        .if_empty_n(if_empty_n), .if_read_ce(if_read_ce), .if_read(if_read), .if_dout(if_dout),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
        .pkt_count(pkt_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(string tag, logic [63:0] got, logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    task automatic push_word(logic [DW-1:0] d, logic last);
        exp_t e;
        e.data = d;
        e.last = last;
        fifo_q.push_back(d);
        exp_q.push_back(e);
    endtask

    // One clock: present the FIFO head, sample just before the rising edge, then pop after the edge.
    task automatic tick();
        logic do_pop;
        exp_t e;
        cyc++;
        if_empty_n = (fifo_q.size() != 0);
        if (if_empty_n) if_dout = fifo_q[0];
        else            if_dout = '0;
        #1;
        s_tvalid  = m_axis_tvalid;
        s_tlast   = m_axis_tlast;
        s_tdata   = m_axis_tdata;
        s_if_read = if_read;
        do_pop    = if_read && if_empty_n;
        if (m_axis_tvalid && m_axis_tready) begin
            acc_cyc.push_back(cyc);
            chk("beat_expected", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("tdata", m_axis_tdata, e.data);
                chk("tlast", 64'(m_axis_tlast), 64'(e.last));
                if (e.last) exp_pkt++;
            end
        end
        @(negedge clk);
        if (do_pop) begin
            void'(fifo_q.pop_front());
            if (fifo_q.size() == 0) empty_cyc = cyc;
        end
    endtask

    task automatic drain(int budget);
        int n = 0;
        while ((exp_q.size() != 0 || fifo_q.size() != 0) && n < budget) begin
            tick();
            n++;
        end
        chk("drain_done", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        logic          have_ref;
        logic [DW-1:0] ref_data;
        logic          ref_last;
        int            n;
        int            t_empty;

        // Reset state, with the FIFO claiming data so that the read gating is exercised.
        @(negedge clk);
        @(negedge clk);
        if_empty_n = 1'b1;
        #1;
        chk("rst_if_read", 64'(if_read), 64'd0);
        chk("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
        chk("rst_tlast", 64'(m_axis_tlast), 64'd0);
        chk("rst_tdata", m_axis_tdata, 64'd0);
        chk("rst_pkt", 64'(pkt_count), 64'd0);
        chk("read_ce", 64'(if_read_ce), 64'd1);
        if_empty_n = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        chk("idle_tvalid", 64'(s_tvalid), 64'd0);
        chk("idle_if_read", 64'(s_if_read), 64'd0);
        chk("idle_pkt", 64'(pkt_count), 64'd0);

        // Full bursts back to back: tlast every BL beats and no bubbles after the first beat.
        acc_cyc.delete();
        for (int i = 0; i < 8; i++) push_word(64'(i), (i % BL) == BL - 1);
        drain(100);
        for (int i = 1; i < 8; i++)
            if (i < acc_cyc.size()) chk("contiguous", 64'(acc_cyc[i]), 64'(acc_cyc[i-1] + 1));
        chk("pkt_burst", 64'(pkt_count), 64'(exp_pkt));

        // Trailing partial packet closed by the idle timeout.
        acc_cyc.delete();
        for (int i = 0; i < 5; i++) push_word(64'(16'h100 + i), (i == 3) || (i == 4));
        drain(100);
        chk("timeout_latency", 64'(acc_cyc.size() == 5 ? acc_cyc[4] : 0), 64'(empty_cyc + TO + 2));
        chk("pkt_timeout", 64'(pkt_count), 64'(exp_pkt));

        // A new word arriving mid-timeout clears the idle count, so word 0 goes out without tlast.
        acc_cyc.delete();
        push_word(64'h200, 1'b0);
        for (int i = 0; i < 3; i++) tick();
        push_word(64'h201, 1'b1);
        tick();
        t_empty = empty_cyc;
        drain(100);
        chk("restart_latency", 64'(acc_cyc.size() == 2 ? acc_cyc[1] : 0), 64'(t_empty + TO + 2));
        chk("pkt_restart", 64'(pkt_count), 64'(exp_pkt));

        // Backpressure: both stages fill, the output holds steady, then drains under a toggling ready.
        m_axis_tready = 1'b0;
        have_ref = 1'b0;
        ref_data = '0;
        ref_last = 1'b0;
        for (int i = 0; i < 10; i++) push_word(64'(16'h300 + i), (i == 3) || (i == 7) || (i == 9));
        for (int i = 0; i < 10; i++) begin
            tick();
            if (i >= 2) chk("stall_if_read", 64'(s_if_read), 64'd0);
            if (s_tvalid) begin
                if (have_ref) begin
                    chk("stall_tdata", s_tdata, ref_data);
                    chk("stall_tlast", 64'(s_tlast), 64'(ref_last));
                end else begin
                    have_ref = 1'b1;
                    ref_data = s_tdata;
                    ref_last = s_tlast;
                end
            end
        end
        chk("stall_held", 64'(have_ref), 64'd1);
        n = 0;
        while ((exp_q.size() != 0 || fifo_q.size() != 0) && n < 300) begin
            m_axis_tready = ~m_axis_tready;
            tick();
            n++;
        end
        chk("bp_drained", 64'(exp_q.size()), 64'd0);
        chk("pkt_bp", 64'(pkt_count), 64'(exp_pkt));
        m_axis_tready = 1'b1;

        // Asynchronous reset partway through a packet; the partial packet is dropped.
        for (int i = 0; i < 4; i++) push_word(64'(16'h400 + i), i == 3);
        n = 0;
        while (exp_q.size() > 2 && n < 50) begin
            tick();
            n++;
        end
        chk("mid_two_beats", 64'(exp_q.size()), 64'd2);
        reset = 1'b1;
        #1;
        chk("arst_tvalid", 64'(m_axis_tvalid), 64'd0);
        chk("arst_tlast", 64'(m_axis_tlast), 64'd0);
        chk("arst_tdata", m_axis_tdata, 64'd0);
        chk("arst_if_read", 64'(if_read), 64'd0);
        chk("arst_pkt", 64'(pkt_count), 64'd0);
        fifo_q.delete();
        exp_q.delete();
        exp_pkt = 0;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) push_word(64'(16'h500 + i), i == 3);
        drain(100);
        chk("pkt_after_rst", 64'(pkt_count), 64'(exp_pkt));
        chk("pkt_after_rst_one", 64'(pkt_count), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
